// File: rtl/cellrv32_npu_activation_control_pkg.sv
// ---------------------------------------------------------------------------
// cellrv32_npu_package
// Shared NPU definitions used by the activation control slice.
//   ACTIVATION_LATENCY         : fixed pipeline depth of the activation unit
//   activation_type_t          : 4-bit activation function code
//   activation_control_state_t : sequencer states
// ---------------------------------------------------------------------------
package cellrv32_npu_package;

  localparam int ACTIVATION_LATENCY = 3;

  typedef enum logic [3:0] {
    NO_ACTIVATION = 4'b0000,
    RELU          = 4'b0001,
    RELU6         = 4'b0010,
    CRELU         = 4'b0011,
    ELU           = 4'b0100,
    SELU          = 4'b0101,
    SOFTPLUS      = 4'b0110,
    SOFTSIGN      = 4'b0111,
    DROPOUT       = 4'b1000,
    SIGMOID       = 4'b1001,
    TANH          = 4'b1010
  } activation_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } activation_control_state_t;

endpackage

// File: rtl/cellrv32_npu_activation_control_if.sv
// ---------------------------------------------------------------------------
// cellrv32_npu_activation_control_if
// Bundles the instruction handshake, accumulator read port, activation unit
// control/data and unified-buffer write port of the activation sequencer.
//   slave  : the sequencer's view (takes instructions, drives reads/writes)
//   master : the environment's view (offers instructions, returns act data)
// ---------------------------------------------------------------------------
interface cellrv32_npu_activation_control_if #(
  parameter int MATRIX_WIDTH   = 14,
  parameter int ACC_ADDR_WIDTH = 9,
  parameter int BUF_ADDR_WIDTH = 24,
  parameter int LENGTH_WIDTH   = 32
);

  logic                            instr_valid_i;
  logic                            instr_ready_o;
  logic [ACC_ADDR_WIDTH-1:0]       instr_acc_addr_i;
  logic [BUF_ADDR_WIDTH-1:0]       instr_buf_addr_i;
  logic [LENGTH_WIDTH-1:0]         instr_length_i;
  logic [3:0]                      instr_function_i;
  logic                            instr_signed_i;

  logic                            acc_read_en_o;
  logic [ACC_ADDR_WIDTH-1:0]       acc_read_addr_o;

  logic                            act_enable_o;
  logic [3:0]                      act_function_o;
  logic                            act_signed_o;
  logic [MATRIX_WIDTH-1:0][7:0]    act_data_i;

  logic                            buf_write_en_o;
  logic [BUF_ADDR_WIDTH-1:0]       buf_write_addr_o;
  logic [MATRIX_WIDTH*8-1:0]       buf_write_data_o;

  logic                            busy_o;
  logic                            done_o;

  modport slave (
    input  instr_valid_i, instr_acc_addr_i, instr_buf_addr_i, instr_length_i,
           instr_function_i, instr_signed_i, act_data_i,
    output instr_ready_o, acc_read_en_o, acc_read_addr_o, act_enable_o,
           act_function_o, act_signed_o, buf_write_en_o, buf_write_addr_o,
           buf_write_data_o, busy_o, done_o
  );

  modport master (
    output instr_valid_i, instr_acc_addr_i, instr_buf_addr_i, instr_length_i,
           instr_function_i, instr_signed_i, act_data_i,
    input  instr_ready_o, acc_read_en_o, acc_read_addr_o, act_enable_o,
           act_function_o, act_signed_o, buf_write_en_o, buf_write_addr_o,
           buf_write_data_o, busy_o, done_o
  );

endinterface

// File: rtl/cellrv32_npu_activation_control_dsr.sv
// ---------------------------------------------------------------------------
// cellrv32_npu_dsr
// Resettable delay shift register: data_o is data_i delayed by DEPTH enabled
// clock edges. All stages clear asynchronously on reset.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   enable_i      : advance the line
//   data_i/data_o : line head / tail
// ---------------------------------------------------------------------------
module cellrv32_npu_dsr #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stages_q [DEPTH];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) stages_q[i] <= '0;
    end else if (enable_i) begin
      stages_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stages_q[i] <= stages_q[i-1];
    end
  end

  assign data_o = stages_q[DEPTH-1];

endmodule

// File: rtl/cellrv32_npu_activation_control.sv
// ---------------------------------------------------------------------------
// cellrv32_npu_activation_control
// Drains a block of accumulator rows through the activation unit into the
// unified buffer, one row per cycle.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   ctrl          : instruction handshake, accumulator read, activation unit
//                   control/data, unified-buffer write, busy/done status
// ---------------------------------------------------------------------------
module cellrv32_npu_activation_control
  import cellrv32_npu_package::*;
#(
  parameter int MATRIX_WIDTH     = 14,
  parameter int ACC_ADDR_WIDTH   = 9,
  parameter int BUF_ADDR_WIDTH   = 24,
  parameter int LENGTH_WIDTH     = 32,
  parameter int ACC_READ_LATENCY = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  cellrv32_npu_activation_control_if.slave ctrl
);

  // Rows leave the accumulator and reach the buffer after this many cycles.
  localparam int DELAY_DEPTH = ACC_READ_LATENCY + ACTIVATION_LATENCY;
  localparam int DRAIN_WIDTH = $clog2(DELAY_DEPTH + 1);

  activation_control_state_t state_q, state_d;

  logic [ACC_ADDR_WIDTH-1:0] acc_base_q;
  logic [BUF_ADDR_WIDTH-1:0] buf_base_q;
  logic [LENGTH_WIDTH-1:0]   length_q;
  logic [LENGTH_WIDTH-1:0]   row_count_q;
  logic [DRAIN_WIDTH-1:0]    drain_count_q;
  activation_type_t          function_q;
  logic                      signed_q;

  logic accept;
  logic issue;
  logic last_row;

  logic [BUF_ADDR_WIDTH:0]   line_in;
  logic [BUF_ADDR_WIDTH:0]   line_out;
  logic [MATRIX_WIDTH*8-1:0] flat_data;

  assign accept   = ctrl.instr_valid_i && (state_q == IDLE);
  assign issue    = (state_q == ISSUE);
  // length_q is never zero in ISSUE, so length_q - 1 cannot underflow and the
  // counter never has to hold more than the largest length.
  assign last_row = (row_count_q == length_q - 1'b1);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (ctrl.instr_length_i != '0) ? ISSUE : DONE;
      ISSUE:   if (last_row) state_d = DRAIN;
      DRAIN:   if (drain_count_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Instruction latch, row counter and drain countdown. The drain counter is
  // loaded on the last issue so DRAIN lasts exactly DELAY_DEPTH cycles, which
  // ends on the cycle the last row is written.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_base_q    <= '0;
      buf_base_q    <= '0;
      length_q      <= '0;
      row_count_q   <= '0;
      drain_count_q <= '0;
      function_q    <= NO_ACTIVATION;
      signed_q      <= 1'b0;
    end else if (accept) begin
      acc_base_q  <= ctrl.instr_acc_addr_i;
      buf_base_q  <= ctrl.instr_buf_addr_i;
      length_q    <= ctrl.instr_length_i;
      row_count_q <= '0;
      function_q  <= activation_type_t'(ctrl.instr_function_i);
      signed_q    <= ctrl.instr_signed_i;
    end else if (issue) begin
      row_count_q <= row_count_q + 1'b1;
      if (last_row) drain_count_q <= DRAIN_WIDTH'(DELAY_DEPTH - 1);
    end else if ((state_q == DRAIN) && (drain_count_q != '0)) begin
      drain_count_q <= drain_count_q - 1'b1;
    end
  end

  // Each issued row carries its buffer address down the line so the write
  // lands on the cycle its activation result appears.
  assign line_in = {issue, buf_base_q + BUF_ADDR_WIDTH'(row_count_q)};

  cellrv32_npu_dsr #(
    .WIDTH (BUF_ADDR_WIDTH + 1),
    .DEPTH (DELAY_DEPTH)
  ) u_write_delay (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .enable_i (1'b1),
    .data_i   (line_in),
    .data_o   (line_out)
  );

  // Lane i of the activation output occupies byte i of the write word.
  always_comb begin
    flat_data = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) flat_data[8*i +: 8] = ctrl.act_data_i[i];
  end

  assign ctrl.instr_ready_o    = (state_q == IDLE);
  assign ctrl.busy_o           = (state_q != IDLE);
  assign ctrl.done_o           = (state_q == DONE);
  assign ctrl.acc_read_en_o    = issue;
  assign ctrl.acc_read_addr_o  = issue ? acc_base_q + ACC_ADDR_WIDTH'(row_count_q) : '0;
  assign ctrl.act_enable_o     = issue || (state_q == DRAIN);
  assign ctrl.act_function_o   = function_q;
  assign ctrl.act_signed_o     = signed_q;
  assign ctrl.buf_write_en_o   = line_out[BUF_ADDR_WIDTH];
  assign ctrl.buf_write_addr_o = line_out[BUF_ADDR_WIDTH-1:0];
  assign ctrl.buf_write_data_o = flat_data;

endmodule

// File: tb/tb_cellrv32_npu_activation_control.sv
// ---------------------------------------------------------------------------
// tb_cellrv32_npu_activation_control
// Drives two sequencers (read latency 1 and 2) with the same directed
// instructions and checks every cycle against a timeline model: an accepted
// instruction of length n at cycle c reads row k at c+1+k, writes it
// read-latency+3 cycles later, and pulses done one cycle after the last write.
// ---------------------------------------------------------------------------
module tb_cellrv32_npu_activation_control;
  import cellrv32_npu_package::*;

  localparam int MW   = 14;
  localparam int MAXC = 64;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  cellrv32_npu_activation_control_if #(.MATRIX_WIDTH(MW), .ACC_ADDR_WIDTH(9),
    .BUF_ADDR_WIDTH(24), .LENGTH_WIDTH(32)) if0 ();
  cellrv32_npu_activation_control_if #(.MATRIX_WIDTH(MW), .ACC_ADDR_WIDTH(9),
    .BUF_ADDR_WIDTH(24), .LENGTH_WIDTH(32)) if1 ();

  cellrv32_npu_activation_control #(.MATRIX_WIDTH(MW), .ACC_READ_LATENCY(1)) dut0 (
    .clk_i (clk_i), .rstn_i (rstn_i), .ctrl (if0));
  cellrv32_npu_activation_control #(.MATRIX_WIDTH(MW), .ACC_READ_LATENCY(2)) dut1 (
    .clk_i (clk_i), .rstn_i (rstn_i), .ctrl (if1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 0;

  // Timeline model, one row per DUT.
  bit         e_rd_en   [2][MAXC];
  logic [8:0] e_rd_addr [2][MAXC];
  bit         e_wr_en   [2][MAXC];
  logic [23:0] e_wr_addr[2][MAXC];
  bit         e_done    [2][MAXC];
  bit         e_busy    [2][MAXC];
  bit         e_en      [2][MAXC];
  logic [3:0] e_func    [2][MAXC];
  bit         e_sgn     [2][MAXC];
  int         accept_cyc[2];

  bit          pend [2];
  logic [8:0]  p_acc;
  logic [23:0] p_buf;
  logic [31:0] p_len;
  logic [3:0]  p_func;
  logic        p_sgn;
  logic [MW-1:0][7:0] act_drv;

  // Observed outputs, indexed by DUT.
  logic        o_ready [2], o_busy [2], o_done [2], o_rd_en [2], o_wr_en [2];
  logic        o_en [2], o_sgn [2];
  logic [3:0]  o_func [2];
  logic [8:0]  o_rd_addr [2];
  logic [23:0] o_wr_addr [2];
  logic [MW*8-1:0] o_wr_data [2];

  assign o_ready[0] = if0.instr_ready_o;    assign o_ready[1] = if1.instr_ready_o;
  assign o_busy[0]  = if0.busy_o;           assign o_busy[1]  = if1.busy_o;
  assign o_done[0]  = if0.done_o;           assign o_done[1]  = if1.done_o;
  assign o_rd_en[0] = if0.acc_read_en_o;    assign o_rd_en[1] = if1.acc_read_en_o;
  assign o_wr_en[0] = if0.buf_write_en_o;   assign o_wr_en[1] = if1.buf_write_en_o;
  assign o_en[0]    = if0.act_enable_o;     assign o_en[1]    = if1.act_enable_o;
  assign o_sgn[0]   = if0.act_signed_o;     assign o_sgn[1]   = if1.act_signed_o;
  assign o_func[0]  = if0.act_function_o;   assign o_func[1]  = if1.act_function_o;
  assign o_rd_addr[0] = if0.acc_read_addr_o;  assign o_rd_addr[1] = if1.acc_read_addr_o;
  assign o_wr_addr[0] = if0.buf_write_addr_o; assign o_wr_addr[1] = if1.buf_write_addr_o;
  assign o_wr_data[0] = if0.buf_write_data_o; assign o_wr_data[1] = if1.buf_write_data_o;

  task automatic checkOutput(input string name, input int d, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc,
               actual, expected);
    end
  endtask

  // Everything from cycle `from` on becomes idle with reset-value controls.
  task automatic clearModel(input int from);
    for (int d = 0; d < 2; d++)
      for (int t = from; t < MAXC; t++) begin
        e_rd_en[d][t] = 0; e_rd_addr[d][t] = '0; e_wr_en[d][t] = 0; e_wr_addr[d][t] = '0;
        e_done[d][t] = 0; e_busy[d][t] = 0; e_en[d][t] = 0; e_func[d][t] = '0;
        e_sgn[d][t] = 0;
      end
  endtask

  task automatic scheduleInstr(input int d, input int c);
    int lat, done_c;
    lat = (d == 0 ? 1 : 2) + 3;
    accept_cyc[d] = c;
    for (int t = c + 1; t < MAXC; t++) begin
      e_func[d][t] = p_func;
      e_sgn[d][t]  = p_sgn;
    end
    if (p_len == 0) begin
      done_c = c + 1;
    end else begin
      for (int k = 0; k < int'(p_len); k++) begin
        if (c + 1 + k < MAXC) begin
          e_rd_en[d][c+1+k]   = 1;
          e_rd_addr[d][c+1+k] = p_acc + 9'(k);
        end
        if (c + 1 + k + lat < MAXC) begin
          e_wr_en[d][c+1+k+lat]   = 1;
          e_wr_addr[d][c+1+k+lat] = p_buf + 24'(k);
        end
      end
      for (int t = c + 1; t <= c + int'(p_len) + lat && t < MAXC; t++) e_en[d][t] = 1;
      done_c = c + int'(p_len) + lat + 1;
    end
    for (int t = c + 1; t <= done_c && t < MAXC; t++) e_busy[d][t] = 1;
    if (done_c < MAXC) e_done[d][done_c] = 1;
  endtask

  task automatic driveInputs();
    for (int i = 0; i < MW; i++) act_drv[i] = 8'((cyc * 7 + i * 13 + 5) & 255);
    if0.act_data_i = act_drv;       if1.act_data_i = act_drv;
    if0.instr_valid_i = pend[0];    if1.instr_valid_i = pend[1];
    if0.instr_acc_addr_i = p_acc;   if1.instr_acc_addr_i = p_acc;
    if0.instr_buf_addr_i = p_buf;   if1.instr_buf_addr_i = p_buf;
    if0.instr_length_i = p_len;     if1.instr_length_i = p_len;
    if0.instr_function_i = p_func;  if1.instr_function_i = p_func;
    if0.instr_signed_i = p_sgn;     if1.instr_signed_i = p_sgn;
  endtask

  task automatic applyStimulus(input logic [8:0] acc, input logic [23:0] bufa,
                               input logic [31:0] len, input logic [3:0] func,
                               input logic sgn);
    p_acc = acc; p_buf = bufa; p_len = len; p_func = func; p_sgn = sgn;
    pend[0] = 1; pend[1] = 1;
    driveInputs();
  endtask

  task automatic runCycles(input int n);
    bit acc_now [2];
    repeat (n) begin
      for (int d = 0; d < 2; d++) begin
        acc_now[d] = pend[d] && rstn_i && !e_busy[d][cyc];
        if (acc_now[d]) scheduleInstr(d, cyc);
      end
      @(posedge clk_i);
      cyc++;
      #1;
      for (int d = 0; d < 2; d++) if (acc_now[d]) pend[d] = 0;
      driveInputs();
    end
  endtask

  task automatic startScenario();
    check_en = 0;
    rstn_i = 0;
    pend[0] = 0; pend[1] = 0;
    p_acc = '0; p_buf = '0; p_len = '0; p_func = '0; p_sgn = 0;
    cyc = 0;
    driveInputs();
    clearModel(0);
    @(posedge clk_i); #1;
    rstn_i = 1;
    @(posedge clk_i); #1;
    cyc = 0;
    driveInputs();
    check_en = 1;
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk_i) begin
    if (check_en && cyc < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        logic [MW*8-1:0] exp_data;
        for (int i = 0; i < MW; i++) exp_data[8*i +: 8] = act_drv[i];
        checkOutput("instr_ready", d, 128'(o_ready[d]), 128'(!e_busy[d][cyc]));
        checkOutput("busy", d, 128'(o_busy[d]), 128'(e_busy[d][cyc]));
        checkOutput("done", d, 128'(o_done[d]), 128'(e_done[d][cyc]));
        checkOutput("act_enable", d, 128'(o_en[d]), 128'(e_en[d][cyc]));
        checkOutput("act_function", d, 128'(o_func[d]), 128'(e_func[d][cyc]));
        checkOutput("act_signed", d, 128'(o_sgn[d]), 128'(e_sgn[d][cyc]));
        checkOutput("acc_read_en", d, 128'(o_rd_en[d]), 128'(e_rd_en[d][cyc]));
        if (e_rd_en[d][cyc])
          checkOutput("acc_read_addr", d, 128'(o_rd_addr[d]), 128'(e_rd_addr[d][cyc]));
        checkOutput("buf_write_en", d, 128'(o_wr_en[d]), 128'(e_wr_en[d][cyc]));
        if (e_wr_en[d][cyc]) begin
          checkOutput("buf_write_addr", d, 128'(o_wr_addr[d]), 128'(e_wr_addr[d][cyc]));
          checkOutput("buf_write_data", d, 128'(o_wr_data[d]), 128'(exp_data));
        end
      end
    end
  end

  initial begin
    // Reset state, sampled while reset is held.
    #2;
    checkOutput("reset_ready", 0, 128'(if0.instr_ready_o), 128'(1));
    checkOutput("reset_busy", 0, 128'(if0.busy_o), 128'(0));
    checkOutput("reset_wr_en", 1, 128'(if1.buf_write_en_o), 128'(0));
    checkOutput("reset_enable", 1, 128'(if1.act_enable_o), 128'(0));

    $display("[TB] basic run");
    startScenario();
    applyStimulus(9'd10, 24'd100, 32'd4, RELU, 1'b0);
    runCycles(14);
    checkOutput("model_rd_addr1", 0, 128'(e_rd_addr[0][1]), 128'(10));
    checkOutput("model_wr_addr5", 0, 128'(e_wr_addr[0][5]), 128'(100));
    checkOutput("model_wr_en8", 0, 128'({e_wr_en[0][8], e_wr_en[0][9]}), 128'(2'b10));
    checkOutput("model_done9", 0, 128'(e_done[0][9]), 128'(1));
    checkOutput("model_ready10", 0, 128'(e_busy[0][10]), 128'(0));

    $display("[TB] wrap");
    startScenario();
    applyStimulus(9'd511, 24'hFFFFFF, 32'd2, TANH, 1'b1);
    runCycles(12);
    checkOutput("model_wrap_rd", 0, 128'(e_rd_addr[0][2]), 128'(0));
    checkOutput("model_wrap_wr", 0, 128'(e_wr_addr[0][6]), 128'(0));

    $display("[TB] zero length");
    startScenario();
    applyStimulus(9'd3, 24'd7, 32'd0, RELU6, 1'b1);
    runCycles(6);
    checkOutput("model_zero_done", 1, 128'(e_done[1][1]), 128'(1));

    $display("[TB] busy back-pressure");
    startScenario();
    applyStimulus(9'd10, 24'd100, 32'd4, RELU, 1'b0);
    runCycles(2);
    applyStimulus(9'd20, 24'd200, 32'd2, SIGMOID, 1'b1);
    runCycles(20);
    checkOutput("model_accept0", 0, 128'(accept_cyc[0]), 128'(10));
    checkOutput("model_accept1", 1, 128'(accept_cyc[1]), 128'(11));

    $display("[TB] reset mid-op");
    startScenario();
    applyStimulus(9'd10, 24'd100, 32'd4, RELU, 1'b1);
    runCycles(6);
    rstn_i = 0;
    pend[0] = 0; pend[1] = 0;
    clearModel(cyc);
    #1;
    checkOutput("async_ready", 0, 128'(if0.instr_ready_o), 128'(1));
    checkOutput("async_wr_en", 0, 128'(if0.buf_write_en_o), 128'(0));
    checkOutput("async_wr_addr", 0, 128'(if0.buf_write_addr_o), 128'(0));
    checkOutput("async_rd_en", 1, 128'(if1.acc_read_en_o), 128'(0));
    checkOutput("async_signed", 1, 128'(if1.act_signed_o), 128'(0));
    runCycles(1);
    rstn_i = 1;
    runCycles(10);

    $display("[TB] latency 2 length 3");
    startScenario();
    applyStimulus(9'd40, 24'd300, 32'd3, CRELU, 1'b0);
    runCycles(14);
    checkOutput("model_lat2_first", 1, 128'({e_wr_en[1][5], e_wr_en[1][6]}), 128'(2'b01));
    checkOutput("model_lat2_en", 1, 128'({e_en[1][8], e_en[1][9]}), 128'(2'b10));

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
